// File: rtl/riscv_pkg.sv
// Shared RV32 constants used by the fetch front end and its benches.
package riscv_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue with flush; storage is a packed entry array,
// pointers wrap naturally because DEPTH is a power of two.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               rptr, wptr;

  // Storage has no reset: stale slots are never visible since count gates them.
  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC register, combinational instruction ROM
// read, and a decoupling queue toward decode with redirect flush.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter int              IMEM_WORDS = 256,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int AW = $clog2(IMEM_WORDS);
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fq_entry_t;

  // Preloaded hierarchically; intentionally no write port.
  logic [XLEN-1:0] i_mem [IMEM_WORDS];

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] word;
  logic [CW-1:0]   fifo_count;
  fq_entry_t       din, dout;
  logic            push_ok, push, pop;

  assign word = i_mem[pc[AW+1:2]];

  assign out_valid = (fifo_count != '0);
  assign push_ok   = (fifo_count < CW'(QDEPTH)) || (out_valid && out_ready);
  // Redirect wins: the head is still consumed by decode, but the flush
  // discards queue state, so no separate pop is needed toward the fifo.
  assign push      = push_ok && !redirect_valid;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign din.pc    = pc;
  assign din.instr = word;

  always_ff @(posedge clk) begin
    if (reset)               pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc & ~XLEN'(3);
    else if (push)           pc <= pc + XLEN'(4);
  end

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (fifo_count)
  );

  assign out_pc    = dout.pc;
  assign out_instr = dout.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based fetch model predicts the
// instruction stream; a negedge monitor compares the head against it.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam int QD = 4;
  localparam int IW = 256;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready, out_valid;
  logic [31:0] redirect_pc, out_instr, out_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .XLEN       (32),
    .IMEM_WORDS (IW),
    .QDEPTH     (QD),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic [31:0] mem_m [IW];
  exp_t        exp_q [$];
  logic [31:0] fpc;
  bit          en = 1'b0;
  int          checks = 0;
  int          passed = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic load(int idx, logic [31:0] v);
    dut.i_mem[idx] = v;
    mem_m[idx]     = v;
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: after reset/redirect the stream restarts at the aligned
  // target; otherwise the next sequential PC is fetched whenever room exists.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      fpc = 32'h0;
    end else if (redirect_valid) begin
      exp_q.delete();
      fpc = redirect_pc & ~32'h3;
    end else if (exp_q.size() < QD) begin
      exp_q.push_back('{pc: fpc, instr: mem_m[(fpc >> 2) % IW]});
      fpc = fpc + 32'd4;
    end
    en = 1'b1;
  end

  // Monitor: head must match the oldest predicted entry; consume on handshake.
  initial forever begin
    @(negedge clk);
    if (en) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        chk("out_pc", out_pc, exp_q[0].pc);
        chk("out_instr", out_instr, exp_q[0].instr);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    for (int i = 0; i < IW; i++) load(i, NOP_INSTR);
    load(0, 32'h3e800093);
    load(1, 32'h00108133);
    load(2, 32'h00102023);
    load(3, 32'h00000103);
    step(2);

    // stream from reset
    reset = 1'b0; out_ready = 1'b1;
    step(8);

    // backpressure until full
    reset = 1'b1; out_ready = 1'b0;
    step();
    reset = 1'b0;
    step(10);
    @(negedge clk);
    chk("bp_count", 32'(dut.fifo_count), 32'd4);
    chk("bp_pc", dut.pc, 32'h10);
    chk("bp_head", out_pc, 32'h0);
    step();
    out_ready = 1'b1;
    step(8);

    // redirect while full to an unaligned target
    out_ready = 1'b0;
    step(6);
    redirect_valid = 1'b1; redirect_pc = 32'h9;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_gap", {31'b0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("redir_pc", out_pc, 32'h8);
    chk("redir_instr", out_instr, 32'h00102023);
    step();
    out_ready = 1'b1;
    step(3);

    // redirect coinciding with a pop
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    step(5);

    // address wrap past the end of instruction memory
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    step();
    @(negedge clk);
    chk("wrap_pc0", out_pc, 32'h3FC);
    step();
    @(negedge clk);
    chk("wrap_pc1", out_pc, 32'h400);
    chk("wrap_instr", out_instr, 32'h3e800093);
    step(3);

    // reset with a full queue
    out_ready = 1'b0;
    step(6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    step();
    @(negedge clk);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h3e800093);
    step();
    out_ready = 1'b1;
    step(4);

    // randomized traffic
    for (int i = 0; i < IW; i++) load(i, $urandom);
    for (int c = 0; c < 1500; c++) begin
      out_ready      = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 16) == 0;
      redirect_pc    = $urandom;
      reset          = ($urandom % 97) == 0;
      step();
    end
    reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    step(3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
